// File: rtl/sram_1rw_ctrl_if.sv
// sram_1rw_ctrl_if: requester-side write/read request and read response bus
interface sram_1rw_ctrl_if #(
   parameter int AW    = 8,
   parameter int WIDTH = 48,
   parameter int SEGS  = 8
);
   logic             wreq_valid;
   logic             wreq_ready;
   logic [AW-1:0]    wreq_addr;
   logic [WIDTH-1:0] wreq_data;
   logic [SEGS-1:0]  wreq_mask;
   logic             rreq_valid;
   logic             rreq_ready;
   logic [AW-1:0]    rreq_addr;
   logic             rresp_valid;
   logic [WIDTH-1:0] rresp_data;
   modport master (
      output wreq_valid, wreq_addr, wreq_data, wreq_mask, rreq_valid, rreq_addr,
      input  wreq_ready, rreq_ready, rresp_valid, rresp_data
   );
   modport slave (
      input  wreq_valid, wreq_addr, wreq_data, wreq_mask, rreq_valid, rreq_addr,
      output wreq_ready, rreq_ready, rresp_valid, rresp_data
   );
endinterface

// File: rtl/sram_1rw_ctrl.sv
// sram_1rw_ctrl: zero-fills a single-port masked SRAM, then arbitrates write/read requests onto it
module sram_1rw_ctrl #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int WIDTH = 48,
   parameter int SEGS  = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   sram_1rw_ctrl_if.slave   req,
   output logic             init_done,
   output logic             sram_en,
   output logic             sram_wmode,
   output logic [AW-1:0]    sram_addr,
   output logic [SEGS-1:0]  sram_wmask,
   output logic [WIDTH-1:0] sram_wdata,
   input  logic [WIDTH-1:0] sram_rdata
);
   typedef enum logic [1:0] {RST, INIT, RUN} state_t;
   state_t           state, state_nx;
   logic [AW-1:0]    init_cnt;
   logic [WIDTH-1:0] hold;
   logic             rv, init, run, wr_fire, rd_fire;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RST;
         init_cnt <= '0;
         rv       <= 1'b0;
         hold     <= '0;
      end else begin
         state    <= state_nx;
         init_cnt <= init ? init_cnt + 1'b1 : init_cnt;
         rv       <= rd_fire;
         if (rv) hold <= sram_rdata;
      end
   end
   // macro data is only valid the cycle after a read, so it is captured for later cycles
   always_comb begin
      init           = state == INIT;
      run            = state == RUN;
      state_nx       = state == RST ? INIT : (init ? (init_cnt == AW'(DEPTH-1) ? RUN : INIT) : RUN);
      wr_fire        = run & req.wreq_valid;
      rd_fire        = run & req.rreq_valid & ~req.wreq_valid;
      req.wreq_ready = run;
      req.rreq_ready = run & ~req.wreq_valid;
      req.rresp_valid = rv;
      req.rresp_data = rv ? sram_rdata : hold;
      init_done      = run;
      sram_en        = init | wr_fire | rd_fire;
      sram_wmode     = init | wr_fire;
      sram_addr      = init ? init_cnt : (wr_fire ? req.wreq_addr : (rd_fire ? req.rreq_addr : '0));
      sram_wmask     = init ? '1 : (wr_fire ? req.wreq_mask : '0);
      sram_wdata     = wr_fire ? req.wreq_data : '0;
   end
endmodule
